// File: rtl/mem_pkg.sv
// Shared definitions for the MEM stage: memory-op encodings, FSM states and op-size decode.
package mem_pkg;

  localparam logic [5:0] MEMOP_LB  = 6'b100000;
  localparam logic [5:0] MEMOP_LH  = 6'b100001;
  localparam logic [5:0] MEMOP_LW  = 6'b100011;
  localparam logic [5:0] MEMOP_LBU = 6'b100100;
  localparam logic [5:0] MEMOP_LHU = 6'b100101;
  localparam logic [5:0] MEMOP_SB  = 6'b101000;
  localparam logic [5:0] MEMOP_SH  = 6'b101001;
  localparam logic [5:0] MEMOP_SW  = 6'b101011;

  typedef enum logic [1:0] {IDLE, REQ, DONE} mem_state_e;

  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} mem_size_e;

  typedef struct packed {
    mem_size_e size;
    logic      sign;
  } mem_dec_t;

  // Unrecognised codes fall back to an unsigned word access.
  function automatic mem_dec_t mem_decode(input logic [5:0] ctrl);
    mem_dec_t d;
    d.size = SZ_WORD;
    d.sign = 1'b0;
    case (ctrl)
      MEMOP_LB, MEMOP_SB: begin d.size = SZ_BYTE; d.sign = 1'b1; end
      MEMOP_LH, MEMOP_SH: begin d.size = SZ_HALF; d.sign = 1'b1; end
      MEMOP_LBU:          d.size = SZ_BYTE;
      MEMOP_LHU:          d.size = SZ_HALF;
      default:            d.size = SZ_WORD;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering for both directions: byte enables and replicated
// store data toward memory, lane select plus sign/zero extension for load data.
module mem_lane_align
  import mem_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic [5:0]  op_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] store_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] ldata_o
);

  mem_dec_t    dec;
  logic [1:0]  blane;
  logic        half_hi;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    dec     = mem_decode(op_i);
    blane   = BIG_ENDIAN ? (2'd3 - offset_i) : offset_i;
    // Halves ignore offset bit 0; big-endian puts offset 0 in the upper half.
    half_hi = BIG_ENDIAN ? ~offset_i[1] : offset_i[1];

    case (blane)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    half_sel = half_hi ? rdata_i[31:16] : rdata_i[15:0];

    be_o    = 4'b1111;
    wdata_o = store_i;
    ldata_o = rdata_i;
    case (dec.size)
      SZ_BYTE: begin
        be_o    = 4'b0001 << blane;
        wdata_o = {4{store_i[7:0]}};
        ldata_o = {{24{dec.sign & byte_sel[7]}}, byte_sel};
      end
      SZ_HALF: begin
        be_o    = half_hi ? 4'b1100 : 4'b0011;
        wdata_o = {2{store_i[15:0]}};
        ldata_o = {{16{dec.sign & half_sel[15]}}, half_sel};
      end
      default: begin
        be_o    = 4'b1111;
        wdata_o = store_i;
        ldata_o = rdata_i;
      end
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: non-memory ops reach WB in 1 cycle; loads/stores take 3+ cycles
// via a req/ack data-memory handshake, holding EXE with STALL_fMEM until the access ends.
module mem_stage
  import mem_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] Instr1_IN,
  input  logic [31:0] Instr1_PC_IN,
  input  logic [31:0] ALU_result1_IN,
  input  logic [4:0]  WriteRegister1_IN,
  input  logic [31:0] MemWriteData1_IN,
  input  logic        RegWrite1_IN,
  input  logic [5:0]  ALU_Control1_IN,
  input  logic        MemRead1_IN,
  input  logic        MemWrite1_IN,
  output logic        STALL_fMEM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] Instr1_OUT,
  output logic [31:0] Instr1_PC_OUT,
  output logic [4:0]  WriteRegister1_OUT,
  output logic [31:0] WriteData1_OUT,
  output logic        RegWrite1_OUT,
  output logic [4:0]  BypassReg1_MEMEXE,
  output logic [31:0] BypassData1_MEMEXE,
  output logic        BypassValid1_MEMEXE
);

  mem_state_e  state_q;
  logic        req_q, we_q, regwrite_q;
  logic [31:0] addr_q, wdata_q, ldata_q;
  logic [3:0]  be_q;
  logic [5:0]  op_q;
  logic [1:0]  off_q;
  logic [31:0] instr_q, pc_q, wbdata_q;
  logic [4:0]  wreg_q;

  logic        memop, is_store;
  logic [5:0]  al_op;
  logic [1:0]  al_off;
  logic [3:0]  al_be;
  logic [31:0] al_wdata, al_ldata;

  assign memop    = MemRead1_IN | MemWrite1_IN;
  assign is_store = MemWrite1_IN & ~MemRead1_IN;

  // The aligner sees the incoming op while launching and the latched op while waiting on ack.
  assign al_op  = (state_q == IDLE) ? ALU_Control1_IN : op_q;
  assign al_off = (state_q == IDLE) ? ALU_result1_IN[1:0] : off_q;

  mem_lane_align #(
    .BIG_ENDIAN(BIG_ENDIAN)
  ) u_align (
    .op_i     (al_op),
    .offset_i (al_off),
    .store_i  (MemWriteData1_IN),
    .rdata_i  (dmem_rdata),
    .be_o     (al_be),
    .wdata_o  (al_wdata),
    .ldata_o  (al_ldata)
  );

  assign STALL_fMEM = ((state_q == IDLE) && memop) || (state_q == REQ);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q    <= IDLE;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      op_q       <= '0;
      off_q      <= '0;
      ldata_q    <= '0;
      instr_q    <= '0;
      pc_q       <= '0;
      wreg_q     <= '0;
      wbdata_q   <= '0;
      regwrite_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (memop) begin
            req_q      <= 1'b1;
            we_q       <= is_store;
            addr_q     <= {ALU_result1_IN[31:2], 2'b00};
            wdata_q    <= al_wdata;
            be_q       <= al_be;
            op_q       <= ALU_Control1_IN;
            off_q      <= ALU_result1_IN[1:0];
            regwrite_q <= 1'b0;
            state_q    <= REQ;
          end else begin
            instr_q    <= Instr1_IN;
            pc_q       <= Instr1_PC_IN;
            wreg_q     <= WriteRegister1_IN;
            wbdata_q   <= ALU_result1_IN;
            regwrite_q <= RegWrite1_IN;
          end
        end
        REQ: begin
          regwrite_q <= 1'b0;
          if (dmem_ack) begin
            req_q   <= 1'b0;
            ldata_q <= al_ldata;
            state_q <= DONE;
          end
        end
        DONE: begin
          instr_q    <= Instr1_IN;
          pc_q       <= Instr1_PC_IN;
          wreg_q     <= WriteRegister1_IN;
          wbdata_q   <= we_q ? ALU_result1_IN : ldata_q;
          regwrite_q <= RegWrite1_IN;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dmem_req            = req_q;
  assign dmem_we             = we_q;
  assign dmem_addr           = addr_q;
  assign dmem_wdata          = wdata_q;
  assign dmem_be             = be_q;
  assign Instr1_OUT          = instr_q;
  assign Instr1_PC_OUT       = pc_q;
  assign WriteRegister1_OUT  = wreg_q;
  assign WriteData1_OUT      = wbdata_q;
  assign RegWrite1_OUT       = regwrite_q;
  assign BypassReg1_MEMEXE   = wreg_q;
  assign BypassData1_MEMEXE  = wbdata_q;
  assign BypassValid1_MEMEXE = regwrite_q && (wreg_q != 5'd0);

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed instructions, a memory responder and a WB scoreboard monitor.
module tb_mem_stage;
  import mem_pkg::*;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] Instr1_IN, Instr1_PC_IN, ALU_result1_IN, MemWriteData1_IN;
  logic [4:0]  WriteRegister1_IN;
  logic        RegWrite1_IN, MemRead1_IN, MemWrite1_IN;
  logic [5:0]  ALU_Control1_IN;
  logic        STALL_fMEM, dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic [31:0] Instr1_OUT, Instr1_PC_OUT, WriteData1_OUT, BypassData1_MEMEXE;
  logic [4:0]  WriteRegister1_OUT, BypassReg1_MEMEXE;
  logic        RegWrite1_OUT, BypassValid1_MEMEXE;

  mem_stage #(.BIG_ENDIAN(1'b1)) dut (
    .CLK(CLK), .RESET(RESET),
    .Instr1_IN(Instr1_IN), .Instr1_PC_IN(Instr1_PC_IN),
    .ALU_result1_IN(ALU_result1_IN), .WriteRegister1_IN(WriteRegister1_IN),
    .MemWriteData1_IN(MemWriteData1_IN), .RegWrite1_IN(RegWrite1_IN),
    .ALU_Control1_IN(ALU_Control1_IN), .MemRead1_IN(MemRead1_IN),
    .MemWrite1_IN(MemWrite1_IN), .STALL_fMEM(STALL_fMEM),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .Instr1_OUT(Instr1_OUT), .Instr1_PC_OUT(Instr1_PC_OUT),
    .WriteRegister1_OUT(WriteRegister1_OUT), .WriteData1_OUT(WriteData1_OUT),
    .RegWrite1_OUT(RegWrite1_OUT), .BypassReg1_MEMEXE(BypassReg1_MEMEXE),
    .BypassData1_MEMEXE(BypassData1_MEMEXE), .BypassValid1_MEMEXE(BypassValid1_MEMEXE)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        bv;
  } wb_t;
  wb_t sb_q[$];

  // Memory responder: acks after resp_wait REQ cycles and checks request stability.
  bit          resp_en = 1'b1;
  logic        force_ack = 1'b0;
  int          resp_wait = 0;
  int          age = 0;
  logic [31:0] resp_rdata = '0;
  logic [31:0] exp_addr = '0, exp_wdata = '0;
  logic [3:0]  exp_be = '0;
  logic        exp_we = 1'b0;

  initial dmem_ack = 1'b0;
  initial dmem_rdata = '0;

  always @(negedge CLK) begin
    if (!resp_en) begin
      dmem_ack = force_ack;
      age = 0;
    end else if (dmem_req) begin
      chk("req_addr", dmem_addr, exp_addr);
      chk("req_we", {31'b0, dmem_we}, {31'b0, exp_we});
      chk("req_be", {28'b0, dmem_be}, {28'b0, exp_be});
      chk("req_wdata", dmem_wdata, exp_wdata);
      dmem_ack   = (age == resp_wait);
      dmem_rdata = resp_rdata;
      age++;
    end else begin
      dmem_ack = 1'b0;
      age = 0;
    end
  end

  // WB monitor: every register write must match the next scoreboard entry.
  always @(negedge CLK) begin
    wb_t e;
    if (RESET && RegWrite1_OUT) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL wb_unexpected rd=%0d data=0x%08h required=no write", WriteRegister1_OUT, WriteData1_OUT);
      end else begin
        e = sb_q.pop_front();
        chk("wb_rd", {27'b0, WriteRegister1_OUT}, {27'b0, e.rd});
        chk("wb_data", WriteData1_OUT, e.data);
        chk("byp_reg", {27'b0, BypassReg1_MEMEXE}, {27'b0, e.rd});
        chk("byp_data", BypassData1_MEMEXE, e.data);
        chk("byp_valid", {31'b0, BypassValid1_MEMEXE}, {31'b0, e.bv});
      end
    end
  end

  task automatic drive_nop();
    Instr1_IN = '0; Instr1_PC_IN = '0; ALU_result1_IN = '0; MemWriteData1_IN = '0;
    WriteRegister1_IN = '0; RegWrite1_IN = 1'b0; ALU_Control1_IN = '0;
    MemRead1_IN = 1'b0; MemWrite1_IN = 1'b0;
  endtask

  // Presents one instruction, holds it while STALL_fMEM is high, counts stall cycles.
  task automatic issue(input string nm, input logic [5:0] ctrl, input logic rd_en,
                       input logic wr_en, input logic regw, input logic [4:0] wreg,
                       input logic [31:0] alu, input logic [31:0] sdata, input int exp_stall);
    int   st_cnt = 0;
    int   cyc = 0;
    logic st;
    @(negedge CLK);
    Instr1_IN = {26'h0, ctrl}; Instr1_PC_IN = 32'h400 + alu;
    ALU_result1_IN = alu; MemWriteData1_IN = sdata; WriteRegister1_IN = wreg;
    RegWrite1_IN = regw; ALU_Control1_IN = ctrl; MemRead1_IN = rd_en; MemWrite1_IN = wr_en;
    forever begin
      #1;
      st = STALL_fMEM;
      if (st) st_cnt++;
      @(posedge CLK);
      cyc++;
      if (!st || cyc > 60) break;
      @(negedge CLK);
    end
    chk({nm, "_timeout"}, {31'b0, cyc > 60}, 32'd0);
    chk({nm, "_stall_cycles"}, st_cnt, exp_stall);
    @(negedge CLK);
    drive_nop();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired before end of test");
    $fatal(1);
  end

  initial begin
    RESET = 1'b0;
    drive_nop();
    #12;
    chk("rst_regwrite", {31'b0, RegWrite1_OUT}, 32'd0);
    chk("rst_wdata", WriteData1_OUT, 32'd0);
    chk("rst_req", {31'b0, dmem_req}, 32'd0);
    chk("rst_stall", {31'b0, STALL_fMEM}, 32'd0);
    @(negedge CLK);
    RESET = 1'b1;

    // ADD r5 = 7
    sb_q.push_back('{rd: 5'd5, data: 32'h7, bv: 1'b1});
    issue("add", 6'b000000, 1'b0, 1'b0, 1'b1, 5'd5, 32'h7, 32'h0, 0);

    // LW r9 from 0x1004, ack in first REQ cycle
    exp_addr = 32'h1004; exp_we = 1'b0; exp_be = 4'b1111; exp_wdata = 32'h0;
    resp_wait = 0; resp_rdata = 32'hDEADBEEF;
    sb_q.push_back('{rd: 5'd9, data: 32'hDEADBEEF, bv: 1'b1});
    issue("lw", MEMOP_LW, 1'b1, 1'b0, 1'b1, 5'd9, 32'h1004, 32'h0, 2);

    // LB / LBU from 0x1001 selects lane 2 (0xF2)
    exp_addr = 32'h1000; exp_be = 4'b0100; resp_rdata = 32'h11F23344;
    sb_q.push_back('{rd: 5'd10, data: 32'hFFFFFFF2, bv: 1'b1});
    issue("lb", MEMOP_LB, 1'b1, 1'b0, 1'b1, 5'd10, 32'h1001, 32'h0, 2);
    sb_q.push_back('{rd: 5'd11, data: 32'h000000F2, bv: 1'b1});
    issue("lbu", MEMOP_LBU, 1'b1, 1'b0, 1'b1, 5'd11, 32'h1001, 32'h0, 2);

    // SH to 0x2002 with 3 wait cycles; no WB write expected
    exp_addr = 32'h2000; exp_we = 1'b1; exp_be = 4'b0011; exp_wdata = 32'hABCDABCD;
    resp_wait = 3; resp_rdata = 32'h0;
    issue("sh", MEMOP_SH, 1'b0, 1'b1, 1'b0, 5'd0, 32'h2002, 32'h0000ABCD, 5);

    // Reset in the middle of a load, followed by a stray ack
    resp_en = 1'b0;
    force_ack = 1'b0;
    @(negedge CLK);
    ALU_result1_IN = 32'h3000; WriteRegister1_IN = 5'd7; RegWrite1_IN = 1'b1;
    ALU_Control1_IN = MEMOP_LW; MemRead1_IN = 1'b1; Instr1_IN = 32'h1234; Instr1_PC_IN = 32'h88;
    @(posedge CLK);
    @(negedge CLK);
    #1;
    chk("t5_req_pre_reset", {31'b0, dmem_req}, 32'd1);
    RESET = 1'b0;
    drive_nop();
    #1;
    chk("t5_req", {31'b0, dmem_req}, 32'd0);
    chk("t5_addr", dmem_addr, 32'd0);
    chk("t5_be", {28'b0, dmem_be}, 32'd0);
    chk("t5_regwrite", {31'b0, RegWrite1_OUT}, 32'd0);
    chk("t5_instr", Instr1_OUT, 32'd0);
    chk("t5_stall", {31'b0, STALL_fMEM}, 32'd0);
    chk("t5_state", {30'b0, dut.state_q}, {30'b0, IDLE});
    @(negedge CLK);
    RESET = 1'b1;
    force_ack = 1'b1;
    @(negedge CLK);
    #1;
    force_ack = 1'b0;
    @(negedge CLK);
    #1;
    chk("t5_late_ack_regwrite", {31'b0, RegWrite1_OUT}, 32'd0);
    chk("t5_late_ack_req", {31'b0, dmem_req}, 32'd0);
    chk("t5_late_ack_state", {30'b0, dut.state_q}, {30'b0, IDLE});
    resp_en = 1'b1;

    // LW to r0: writes, but must not be advertised on the bypass
    exp_addr = 32'h40; exp_we = 1'b0; exp_be = 4'b1111; exp_wdata = 32'h0;
    resp_wait = 0; resp_rdata = 32'h12345678;
    sb_q.push_back('{rd: 5'd0, data: 32'h12345678, bv: 1'b0});
    issue("lw_r0", MEMOP_LW, 1'b1, 1'b0, 1'b1, 5'd0, 32'h40, 32'h0, 2);

    repeat (3) @(negedge CLK);
    chk("scoreboard_drained", sb_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipeline MEM stage: the consumer of the EXE stage's registered outputs and the producer of the signals EXE listens to, STALL_fMEM and the BypassReg1/Data1/Valid1_MEMEXE forwarding bus.
- Non-memory instructions pass to WB in one cycle.
- Loads and stores run a req/ack handshake on the data-memory port and stall EXE until the access completes.

Parameters:
- BIG_ENDIAN, 1, byte-lane mapping: 1 = MIPS big-endian (offset 0 in lane 3), 0 = little-endian (offset 0 in lane 0).

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RESET  in  1  asynchronous, active-low reset.
- Instr1_IN  in  32  instruction from EXE (debug).
- Instr1_PC_IN  in  32  PC from EXE (debug).
- ALU_result1_IN  in  32  ALU result, or effective address for loads/stores.
- WriteRegister1_IN  in  5  destination register.
- MemWriteData1_IN  in  32  store data, already forwarded.
- RegWrite1_IN  in  1  instruction writes a register.
- ALU_Control1_IN  in  6  selects the memory op size/sign.
- MemRead1_IN  in  1  load.
- MemWrite1_IN  in  1  store.
- STALL_fMEM  out  1  EXE must hold its outputs.
- dmem_req  out  1  memory request valid.
- dmem_we  out  1  1 = write.
- dmem_addr  out  32  word-aligned address ({addr[31:2],2'b00}).
- dmem_wdata  out  32  lane-replicated store data.
- dmem_be  out  4  byte enables; bit i covers data[8i+7:8i].
- dmem_ack  in  1  memory completes the request this cycle.
- dmem_rdata  in  32  read word, valid when dmem_ack=1.
- Instr1_OUT  out  32  instruction to WB (debug).
- Instr1_PC_OUT  out  32  PC to WB (debug).
- WriteRegister1_OUT  out  5  destination register to WB.
- WriteData1_OUT  out  32  result to WB.
- RegWrite1_OUT  out  1  WB register write enable.
- BypassReg1_MEMEXE  out  5  equals WriteRegister1_OUT.
- BypassData1_MEMEXE  out  32  equals WriteData1_OUT.
- BypassValid1_MEMEXE  out  1  RegWrite1_OUT && WriteRegister1_OUT!=0.

Behaviour:
- Reset: all registered outputs 0, dmem_req=0, FSM=IDLE.
  - Reset is asynchronous and may arrive mid-access.
  - A dmem_ack arriving after reset is ignored, because IDLE never samples dmem_ack.
- memop = MemRead1_IN|MemWrite1_IN. If both are set, treat it as a load.
- FSM states IDLE, REQ, DONE:
  - IDLE, memop=0: STALL_fMEM=0. WB regs latch IN values; WriteData1_OUT<=ALU_result1_IN.
  - IDLE, memop=1: STALL_fMEM=1 (combinational). Latch dmem_addr/we/wdata/be and set dmem_req<=1; go to REQ. WB gets a bubble (RegWrite1_OUT<=0).
  - REQ: STALL_fMEM=1, dmem_req held with stable addr/data/be.
    - On dmem_ack: dmem_req<=0; capture extended load data into ldata; go to DONE.
    - Bubble to WB every REQ cycle.
  - DONE: STALL_fMEM=0, so EXE advances at this edge. WB latches ldata for loads (ALU_result1_IN for stores, with RegWrite from IN, normally 0); go to IDLE.
- Timing:
  - Load/store latency with ack in the first REQ cycle: 3 cycles in MEM (STALL high for 2 cycles).
  - Each extra wait cycle adds 1.
- Back-to-back memops: DONE always returns to IDLE, so the second op starts fresh; there is no overlap.
- Memory op encodings (ALU_Control1_IN):
  - LB 100000, LH 100001, LW 100011, LBU 100100, LHU 100101.
  - SB 101000, SH 101001, SW 101011.
  - Any other code with memop=1 acts as word.
- Lane mapping, for offset k=addr[1:0]:
  - BIG_ENDIAN=1: byte lane 3-k; half lanes {3,2} for k[1]=0 and {1,0} for k[1]=1.
  - BIG_ENDIAN=0: byte lane k; half lanes {1,0} for k[1]=0 and {3,2} for k[1]=1.
  - Word: be=1111.
  - Misalignment is ignored: half uses addr[1] only, word ignores addr[1:0].
- Store data: SB wdata={4{d[7:0]}}, SH {2{d[15:0]}}, SW d.
- Loads: LB/LH sign-extend, LBU/LHU zero-extend from the selected lane(s).
- Bypass reflects the WB-stage registers and is always the 2nd-priority forward for EXE.

Decomposition:
- mem_pkg: MEMOP_* 6-bit constants; FSM state enum {IDLE,REQ,DONE}; size/sign decode function.
- Sub-module mem_lane_align, combinational, shared by both directions:
  - Inputs: op, offset, store data, read word.
  - Outputs: be, wdata, extended load data.

Test Plan:
1. ADD result 0x00000007 to r5 in IDLE -> next cycle RegWrite1_OUT=1, WriteData1_OUT=7, Bypass valid reg 5; STALL_fMEM never high.
2. LW addr 0x1004, ack in first REQ cycle, rdata 0xDEADBEEF:
   - STALL high 2 cycles; dmem_addr 0x1004, be 1111.
   - WriteData1_OUT=0xDEADBEEF one cycle after DONE.
3. LB addr 0x1001, rdata 0x11F2_3344, BIG_ENDIAN=1 -> lane 2 (0xF2), WriteData=0xFFFFFFF2. Repeat as LBU -> 0x000000F2.
4. SH addr 0x2002, data 0x0000ABCD, ack after 3 wait cycles:
   - dmem_we=1, be 0011, wdata 0xABCDABCD, stable throughout.
   - STALL high 5 cycles; RegWrite1_OUT stays 0.
5. RESET low during REQ, ack arriving one cycle after release:
   - All outputs 0, dmem_req 0, state IDLE.
   - Late ack causes no WB write.
6. LW to r0 -> RegWrite1_OUT=1 but BypassValid1_MEMEXE=0.
